ddr3_fill_pattern_gen: RTL and testbench
========================================

Name: ddr3_fill_pattern_gen

Overview:
- Upstream request source for the single-word DDR3 Avalon writer; drives that writer's test_addr / test_wr_data / test_wr inputs.
- Fills a contiguous DDR3 word region with a selectable pattern: incrementing, address-as-data, VGA colour bars, or a constant.
- Used for frame-buffer bring-up and memory test.
- The writer has no busy output, so this block paces itself by monitoring the writer's Avalon write_req/ready pair and issues the next word only after the current word is accepted.

Parameters:
- BASE_ADDR, 32'h0, word address of first write.
- NUM_WORDS, 307200, words per fill (640x480); must be ≥1.
- ADDR_STEP, 1, address increment per word.
- H_ACTIVE, 640, pixels per line (colour-bar x wrap).
- BAR_WIDTH, 80, pixels per colour bar.
- TIMEOUT, 1024, max cycles waiting for one acceptance.

Ports:
- ddr3_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a fill when idle.
- abort  in  1  level; stops after the in-flight word is accepted.
- pattern_sel  in  2  0=incrementing index, 1=address, 2=colour bars, 3=constant; sampled on start.
- fill_value  in  32  constant for pattern 3; sampled on start.
- mon_write_req  in  1  writer's ddr3_avl_write_req.
- mon_avl_ready  in  1  controller's ddr3_avl_ready.
- test_addr  out  32  word address to writer.
- test_wr_data  out  32  data to writer.
- test_wr  out  1  one-cycle write strobe.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of fill (normal, abort or timeout).
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- words_written  out  32  count of accepted words in the current or last fill.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; internal counters 0.
- Reset mid-fill returns the block immediately to IDLE with no done pulse.
- States: IDLE, ISSUE, WAIT_ACK, FINISH.
- IDLE:
  - start → latch pattern_sel/fill_value; idx=0; addr=BASE_ADDR; x=0; bar=0; words_written=0; error=0; busy=1; go to ISSUE.
  - start while not IDLE is ignored.
- ISSUE (exactly one cycle):
  - test_wr=1 in the following cycle; test_addr/test_wr_data are valid with it and held stable until the next issue.
  - Clear timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - Acceptance = mon_write_req && mon_avl_ready in the same cycle.
  - On acceptance: words_written++, advance idx/addr/x/bar.
    - If idx+1==NUM_WORDS or abort → FINISH.
    - Else → ISSUE.
  - Next test_wr lands one cycle after acceptance, which is the writer's IDLE cycle. Back-to-back throughput is one word per 3 cycles when ready is high.
  - Timeout counter increments each non-accepting cycle. Reaching TIMEOUT → error=1, FINISH.
  - abort without acceptance does not exit WAIT_ACK; the in-flight write cannot be cancelled.
- FINISH: done=1 for one cycle; busy=0; → IDLE.
- Data generation:
  - pattern 0: data=idx.
  - pattern 1: data=addr.
  - pattern 2: data={8'h00, RGB of bar}, see below.
  - pattern 3: data=fill_value.
- Colour bars (bar 0..7, 24-bit RGB): FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - x increments per word. When x reaches BAR_WIDTH multiples, bar++.
  - When x==H_ACTIVE-1: x wraps to 0 and bar wraps to 0.
  - bar saturates at 7 if H_ACTIVE > 8*BAR_WIDTH.
- Address arithmetic is 32-bit modulo 2^32 (wrap permitted). The writer uses [25:0] only.
- abort asserted in the same cycle as acceptance of the last word: normal completion; done pulses once.

Decomposition:
- Shared package ddr3_ctrl_pkg holds:
  - state encoding;
  - pattern_sel constants PAT_INC, PAT_ADDR, PAT_BARS, PAT_CONST;
  - the 8-entry colour-bar RGB constant table.
- One sub-module is natural: pattern_data_gen. It covers idx/addr/x/bar counters plus the data mux, with advance and load strobes from the FSM.

Test Plan:
- NUM_WORDS=4, pattern 0, mon_avl_ready tied 1 with a writer model:
  - expect 4 test_wr pulses with addr 0,1,2,3 and data 0,1,2,3;
  - pulses spaced 3 cycles apart;
  - done once; words_written=4.
- pattern 2, H_ACTIVE=16, BAR_WIDTH=2, NUM_WORDS=20:
  - data sequence is 00FFFFFF x2, 00FFFF00 x2 … 00000000 x2, then wraps to 00FFFFFF at word 16.
- Backpressure: ready low for 5 cycles after each write_req → no new test_wr until acceptance; addr/data stable throughout.
- TIMEOUT=8, ready held 0:
  - after 8 wait cycles, error=1, done pulse, words_written=0;
  - next start clears error.
- abort raised mid-wait on word 2 of 10, acceptance 3 cycles later:
  - done follows; words_written=3; no further test_wr.
- reset asserted during WAIT_ACK: outputs immediately 0; start after release begins a fresh fill at BASE_ADDR; start while busy is ignored.

Source files
------------

// File: rtl/ddr3_ctrl_pkg.sv
// Shared definitions for the DDR3 fill pattern generator: FSM encoding,
// pattern selectors and the colour-bar palette.
package ddr3_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_FINISH   = 2'd3
  } fill_state_e;

  localparam logic [1:0] PAT_INC   = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam int unsigned NUM_BARS = 8;

  // Standard 8-bar test pattern, left to right, 24-bit RGB
  localparam logic [23:0] BAR_RGB [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/pattern_data_gen.sv
// Word index / address / pixel position counters and the pattern data mux
// for the DDR3 fill generator; loaded at fill start, advanced per accepted word.
module pattern_data_gen
  import ddr3_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned BAR_WIDTH = 80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [1:0]  i_pattern_sel,
  input  logic [31:0] i_fill_value,
  output logic [31:0] o_idx,
  output logic [31:0] o_addr,
  output logic [31:0] o_data_c
);

  localparam int unsigned X_W  = (H_ACTIVE  > 1) ? $clog2(H_ACTIVE)  : 1;
  localparam int unsigned BX_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  logic [31:0]     r_idx;
  logic [31:0]     r_addr;
  logic [X_W-1:0]  r_x;
  logic [BX_W-1:0] r_bx;
  logic [2:0]      r_bar;
  logic [1:0]      r_pat;
  logic [31:0]     r_fill;
  logic            w_line_end;
  logic            w_bar_end;

  assign w_line_end = (r_x == X_W'(H_ACTIVE - 1));
  assign w_bar_end  = (r_bx == BX_W'(BAR_WIDTH - 1));

  // r_bx counts pixels within the current bar so no divider is needed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_x    <= '0;
      r_bx   <= '0;
      r_bar  <= '0;
      r_pat  <= '0;
      r_fill <= '0;
    end else if (i_load) begin
      r_idx  <= '0;
      r_addr <= BASE_ADDR;
      r_x    <= '0;
      r_bx   <= '0;
      r_bar  <= '0;
      r_pat  <= i_pattern_sel;
      r_fill <= i_fill_value;
    end else if (i_advance) begin
      r_idx  <= r_idx + 32'd1;
      r_addr <= r_addr + ADDR_STEP;
      if (w_line_end) begin
        r_x   <= '0;
        r_bx  <= '0;
        r_bar <= '0;
      end else begin
        r_x <= r_x + X_W'(1);
        if (w_bar_end) begin
          r_bx <= '0;
          if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
        end else begin
          r_bx <= r_bx + BX_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_data_c = r_fill;
    case (r_pat)
      PAT_INC:  o_data_c = r_idx;
      PAT_ADDR: o_data_c = r_addr;
      PAT_BARS: o_data_c = {8'h00, BAR_RGB[r_bar]};
      default:  o_data_c = r_fill;
    endcase
  end

  assign o_idx  = r_idx;
  assign o_addr = r_addr;

endmodule

// File: rtl/ddr3_fill_pattern_gen.sv
// Fills a DDR3 word region with a selectable pattern through the single-word
// Avalon writer, pacing itself on the writer's write_req/ready handshake.
module ddr3_fill_pattern_gen
  import ddr3_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned NUM_WORDS = 307200,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned BAR_WIDTH = 80,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        ddr3_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  pattern_sel,
  input  logic [31:0] fill_value,
  input  logic        mon_write_req,
  input  logic        mon_avl_ready,
  output logic [31:0] test_addr,
  output logic [31:0] test_wr_data,
  output logic        test_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  fill_state_e      r_state, w_state_nxt;
  logic [31:0]      r_test_addr, w_test_addr_nxt;
  logic [31:0]      r_test_wr_data, w_test_wr_data_nxt;
  logic             r_test_wr, w_test_wr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
  logic [31:0]      r_words, w_words_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             w_load;
  logic             w_advance;
  logic             w_accept;
  logic [31:0]      w_idx;
  logic [31:0]      w_gen_addr;
  logic [31:0]      w_gen_data;

  assign w_accept = mon_write_req && mon_avl_ready;

  pattern_data_gen #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_STEP (ADDR_STEP),
    .H_ACTIVE  (H_ACTIVE),
    .BAR_WIDTH (BAR_WIDTH)
  ) u_pattern_data_gen (
    .i_clk         (ddr3_clk),
    .i_rst         (reset),
    .i_load        (w_load),
    .i_advance     (w_advance),
    .i_pattern_sel (pattern_sel),
    .i_fill_value  (fill_value),
    .o_idx         (w_idx),
    .o_addr        (w_gen_addr),
    .o_data_c      (w_gen_data)
  );

  always_ff @(posedge ddr3_clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_test_addr    <= '0;
      r_test_wr_data <= '0;
      r_test_wr      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words        <= '0;
      r_tmo          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_test_addr    <= w_test_addr_nxt;
      r_test_wr_data <= w_test_wr_data_nxt;
      r_test_wr      <= w_test_wr_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_error        <= w_error_nxt;
      r_words        <= w_words_nxt;
      r_tmo          <= w_tmo_nxt;
    end
  end

  // Addr/data only change on ISSUE so they stay stable while the writer holds write_req
  always_comb begin
    w_state_nxt        = r_state;
    w_test_addr_nxt    = r_test_addr;
    w_test_wr_data_nxt = r_test_wr_data;
    w_test_wr_nxt      = 1'b0;
    w_busy_nxt         = r_busy;
    w_done_nxt         = 1'b0;
    w_error_nxt        = r_error;
    w_words_nxt        = r_words;
    w_tmo_nxt          = r_tmo;
    w_load             = 1'b0;
    w_advance          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_words_nxt = '0;
          w_error_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_test_wr_nxt      = 1'b1;
        w_test_addr_nxt    = w_gen_addr;
        w_test_wr_data_nxt = w_gen_data;
        w_tmo_nxt          = '0;
        w_state_nxt        = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (w_accept) begin
          w_advance   = 1'b1;
          w_words_nxt = r_words + 32'd1;
          if ((w_idx == 32'(NUM_WORDS - 1)) || abort) w_state_nxt = ST_FINISH;
          else                                        w_state_nxt = ST_ISSUE;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_FINISH;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign test_addr     = r_test_addr;
  assign test_wr_data  = r_test_wr_data;
  assign test_wr       = r_test_wr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign words_written = r_words;

endmodule

// File: tb/tb_ddr3_fill_pattern_gen.sv
// Directed bench for ddr3_fill_pattern_gen with a single-word writer model and
// an expected-write scoreboard queue.
module tb_ddr3_fill_pattern_gen;

  localparam logic [31:0] TB_BASE  = 32'hFFFF_FFFC;
  localparam logic [31:0] TB_STEP  = 32'd2;
  localparam int          TB_WORDS = 20;
  localparam int          TB_H     = 16;
  localparam int          TB_BW    = 2;
  localparam int          TB_TMO   = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  pattern_sel;
  logic [31:0] fill_value;
  logic        write_req;
  logic        avl_ready;
  logic [31:0] test_addr;
  logic [31:0] test_wr_data;
  logic        test_wr;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  int   total;
  int   bad;
  int   bp_len;
  int   hold;
  logic force_low;
  exp_t exp_q[$];

  ddr3_fill_pattern_gen #(
    .BASE_ADDR (TB_BASE),
    .NUM_WORDS (TB_WORDS),
    .ADDR_STEP (TB_STEP),
    .H_ACTIVE  (TB_H),
    .BAR_WIDTH (TB_BW),
    .TIMEOUT   (TB_TMO)
  ) dut (
    .ddr3_clk      (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .pattern_sel   (pattern_sel),
    .fill_value    (fill_value),
    .mon_write_req (write_req),
    .mon_avl_ready (avl_ready),
    .test_addr     (test_addr),
    .test_wr_data  (test_wr_data),
    .test_wr       (test_wr),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writer model: write_req rises the cycle after test_wr, drops on acceptance
  assign avl_ready = !force_low && (hold == 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_req <= 1'b0;
      hold      <= 0;
    end else if (!write_req && test_wr) begin
      write_req <= 1'b1;
      hold      <= bp_len;
    end else if (write_req) begin
      if (avl_ready) write_req <= 1'b0;
      else if (hold > 0) hold <= hold - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] p, input int k, input logic [31:0] fv);
    int x;
    int b;
    logic [23:0] rgb;
    x = k % TB_H;
    b = x / TB_BW;
    if (b > 7) b = 7;
    case (b)
      0:       rgb = 24'hFFFFFF;
      1:       rgb = 24'hFFFF00;
      2:       rgb = 24'h00FFFF;
      3:       rgb = 24'h00FF00;
      4:       rgb = 24'hFF00FF;
      5:       rgb = 24'hFF0000;
      6:       rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    case (p)
      2'd0:    return 32'(k);
      2'd1:    return TB_BASE + 32'(k) * TB_STEP;
      2'd2:    return {8'h00, rgb};
      default: return fv;
    endcase
  endfunction

  task automatic push_fill(input logic [1:0] p, input logic [31:0] fv, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.a = TB_BASE + 32'(k) * TB_STEP;
      e.d = model(p, k, fv);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [1:0] p, input logic [31:0] fv);
    pattern_sel = p;
    fill_value  = fv;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic check_pulse(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra_wr"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, test_addr, e.a);
      chk({tag, "_data"}, test_wr_data, e.d);
    end
  endtask

  // Runs one fill to its done pulse plus a few idle cycles, checking every write
  task automatic run_fill(input string tag, input bit gap_chk, input int abort_at,
                          input int max_cyc, input int exp_pulses,
                          input logic [31:0] exp_words, input logic exp_err);
    int cyc;
    int last;
    int pulses;
    int dones;
    int post;
    int stab_bad;
    logic [31:0] cur_a;
    logic [31:0] cur_d;
    cyc = 0; last = 0; pulses = 0; dones = 0; post = -1; stab_bad = 0;
    cur_a = test_addr;
    cur_d = test_wr_data;
    while (cyc < max_cyc && post != 0) begin
      @(negedge clk);
      cyc++;
      if (test_wr) begin
        pulses++;
        check_pulse(tag);
        chk({tag, "_busy_wr"}, 32'(busy), 32'd1);
        if (gap_chk && pulses > 1) chk({tag, "_gap"}, 32'(cyc - last), 32'd3);
        last  = cyc;
        cur_a = test_addr;
        cur_d = test_wr_data;
      end else if (write_req && (test_addr !== cur_a || test_wr_data !== cur_d)) begin
        stab_bad++;
      end
      if (abort_at >= 0 && pulses == abort_at + 1 && write_req) abort = 1'b1;
      if (done) begin
        dones++;
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
    end
    abort = 1'b0;
    chk({tag, "_done_cnt"}, 32'(dones), 32'd1);
    chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, "_words"}, words_written, exp_words);
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pulse(input string tag, input int max_cyc);
    int cyc;
    cyc = 0;
    while (cyc < max_cyc && !test_wr) begin
      @(negedge clk);
      cyc++;
    end
    if (test_wr) check_pulse(tag);
    else chk({tag, "_wr_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int cyc;
    cyc = 0;
    while (cyc < max_cyc && !write_req) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_req_seen"}, 32'(write_req), 32'd1);
  endtask

  initial begin
    int quiet;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern_sel = 2'd0; fill_value = '0;
    bp_len = 0; force_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_test_wr", 32'(test_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", words_written, 32'd0);
    chk("rst_addr", test_addr, 32'd0);
    chk("rst_data", test_wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Incrementing pattern, ready always high: addresses wrap past 2^32
    push_fill(2'd0, 32'h0, TB_WORDS);
    do_start(2'd0, 32'h0);
    chk("inc_busy_start", 32'(busy), 32'd1);
    run_fill("inc", 1'b1, -1, 200, TB_WORDS, 32'(TB_WORDS), 1'b0);

    // Colour bars: two words per bar, line wrap at word 16
    push_fill(2'd2, 32'h0, TB_WORDS);
    do_start(2'd2, 32'h0);
    run_fill("bars", 1'b1, -1, 200, TB_WORDS, 32'(TB_WORDS), 1'b0);

    // Constant pattern under 5-cycle backpressure
    bp_len = 5;
    push_fill(2'd3, 32'hDEAD_BEEF, TB_WORDS);
    do_start(2'd3, 32'hDEAD_BEEF);
    run_fill("bp", 1'b0, -1, 400, TB_WORDS, 32'(TB_WORDS), 1'b0);

    // Timeout with ready held low
    bp_len = 0;
    force_low = 1'b1;
    push_fill(2'd1, 32'h0, 1);
    do_start(2'd1, 32'h0);
    run_fill("tmo", 1'b0, -1, 60, 1, 32'd0, 1'b1);
    force_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("tmo_error_sticky", 32'(error), 32'd1);

    // Next start clears error; address pattern
    push_fill(2'd1, 32'h0, TB_WORDS);
    do_start(2'd1, 32'h0);
    chk("clr_error", 32'(error), 32'd0);
    chk("clr_words", words_written, 32'd0);
    run_fill("addr", 1'b1, -1, 200, TB_WORDS, 32'(TB_WORDS), 1'b0);

    // Abort during wait on word 2, accepted 3 cycles later
    bp_len = 3;
    push_fill(2'd0, 32'h0, 3);
    do_start(2'd0, 32'h0);
    run_fill("abort", 1'b0, 2, 200, 3, 32'd3, 1'b0);

    // Start while busy ignored, then reset during WAIT_ACK
    bp_len = 5;
    push_fill(2'd0, 32'h0, 2);
    do_start(2'd0, 32'h0);
    wait_pulse("busy_w0", 20);
    wait_req("busy_w0", 20);
    do_start(2'd3, 32'h1234_5678);
    @(negedge clk);
    wait_pulse("busy_w1", 30);
    chk("busy_words1", words_written, 32'd1);
    wait_req("busy_w1", 20);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_test_wr", 32'(test_wr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words", words_written, 32'd0);
    chk("mid_rst_addr", test_addr, 32'd0);
    chk("mid_rst_data", test_wr_data, 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || test_wr) quiet++;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd0);

    bp_len = 0;
    exp_q.delete();
    push_fill(2'd0, 32'h0, TB_WORDS);
    do_start(2'd0, 32'h0);
    run_fill("fresh", 1'b1, -1, 200, TB_WORDS, 32'(TB_WORDS), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
